adder_response_checker: RTL and testbench
=========================================

# adder_response_checker

Synthesizable response checker for the 4-bit parallel adder: it observes the operands driven into the adder and the adder's sum, internal carries and carry-out. It compares them against a golden ripple model, counts vectors and mismatches, and captures the first failing vector. It sits beside the adder in the lab test harness, at the consuming end of the stimulus path, so results can be read on board LEDs or in simulation without a waveform.

## Interface
Parameters:
- NUM_VECTORS, 256: number of accepted vectors after which the check run ends (1..65535).
- CHECK_CARRIES, 1: when 1, internal carries c[3:1] are part of the comparison; when 0, only s and cout are compared.

Ports (one clock; reset is synchronous and active-low):
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- clear  in  1  synchronous restart of the run; counters and capture are zeroed.
- in_valid  in  1  the operands and adder outputs on this cycle form one vector.
- a  in  4  adder operand A.
- b  in  4  adder operand B.
- cin  in  1  adder carry-in.
- s  in  4  adder sum under test.
- c  in  3  adder internal carries c[3:1] under test.
- cout  in  1  adder carry-out under test.
- busy  out  1  state is RUN.
- done  out  1  state is DONE.
- pass  out  1  done and err_count == 0.
- fail  out  1  err_count != 0; valid in any state.
- mismatch  out  1  one-cycle pulse for a failing vector.
- vec_count  out  16  number of vectors accepted.
- err_count  out  8  number of mismatches, saturating.
- ff_a, ff_b  out  4 each  operands of the first failing vector.
- ff_cin  out  1  carry-in of the first failing vector.
- ff_s  out  4  sum of the first failing vector.
- ff_cout  out  1  carry-out of the first failing vector.

## Operation
- FSM states:
  - IDLE → RUN on the first in_valid.
  - RUN → DONE on the edge where vec_count reaches NUM_VECTORS.
  - DONE holds until clear or reset, either of which returns to IDLE.
- Stage 1 (capture): on in_valid in IDLE or RUN, register a, b, cin, s, c, cout and set v1 = 1. Otherwise v1 = 0. in_valid is ignored in DONE.
- Stage 2 (compare): the golden model computes {gcout, gs} = a + b + cin, 5-bit unsigned, and gc[i] = carry into bit i, i = 1..3.
  - The vector is a mismatch if s != gs, or cout != gcout, or (CHECK_CARRIES and c != gc).
  - On the edge after capture, vec_count increments; on a mismatch, err_count increments.
  - mismatch is registered high for exactly that one cycle.
- First-fail capture loads only while err_count == 0. Later failures never overwrite it.
- Saturation:
  - err_count saturates at 255 and never wraps.
  - vec_count is bounded by NUM_VECTORS.
- pass and fail are registered outputs derived from next state and counts.

## Timing
- Reset (rst_n = 0 at an edge): state IDLE, v1 = 0, all outputs 0, including counts and ff_* fields.
- Latency:
  - inputs sampled at edge N;
  - mismatch, vec_count and err_count update at edge N+1;
  - done and pass are high after edge N+1 for the final vector.
- Throughput: one vector per cycle. Back-to-back in_valid is fully supported.
- clear vs. in_valid on the same edge: clear wins. The vector is dropped and the pipeline flushed (v1 = 0).
- Reset or clear mid-run discards a vector still in stage 1. No mismatch pulse follows.
- The vector that reaches NUM_VECTORS is still counted and checked. in_valid on that same edge is captured in stage 1, then discarded when the FSM enters DONE.

## Structure
- Package adder_chk_pkg holds:
  - the state enum {IDLE, RUN, DONE};
  - constants OPW = 4, VCW = 16, ECW = 8, ERR_MAX = 8'd255.
- One sub-module, adder_golden_model: a combinational 4-bit ripple reference with outputs gs[3:0], gc[3:1] and gcout. It is instantiated once in stage 2.
- Top level contains the capture register, the FSM, the counters and the first-fail register.

## Test plan
- Single-vector pass: reset; drive a = 7, b = 9, cin = 1, s = 4'b0001, c = 3'b111, cout = 1 with in_valid for 1 cycle, NUM_VECTORS = 1. Required: after edge N+1, vec_count = 1, err_count = 0, done = 1, pass = 1, mismatch never high.
- Sum fault: a = 3, b = 4, cin = 0, s = 6, cout = 0. Required: mismatch pulses one cycle at N+1, err_count = 1, ff_a = 3, ff_b = 4, ff_s = 6, fail = 1.
- Carry-only fault: a = 1, b = 1, cin = 0, s = 2, cout = 0, c = 3'b000 (golden c = 3'b001). Required:
  - CHECK_CARRIES = 1: err_count = 1;
  - CHECK_CARRIES = 0: err_count = 0.
- Exhaustive sweep: 512 back-to-back correct vectors covering all a, b, cin, with NUM_VECTORS = 512. Required: done asserts exactly after the 512th compare edge, pass = 1, vec_count = 512.
- Saturation and first-fail hold: 300 consecutive failing vectors, the first with a = 15, b = 15, cin = 1, s = 0. Required: err_count = 255 and not 44; ff_a = 15, ff_s = 0 unchanged after the first failure.
- Clear/reset mid-run: clear asserted together with in_valid during RUN. Required: that vector is dropped, all counts are 0 and state is IDLE on the next cycle. A repeat of the same check with rst_n = 0 gives identical results.

Source files
------------

// File: rtl/adder_chk_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package     : adder_chk_pkg                                              |
// | Description : Shared types and constants for the adder response checker. |
// |               Holds the checker FSM state encoding and the datapath and  |
// |               counter widths.                                            |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package adder_chk_pkg;

  // Checker run state: waiting for the first vector, checking, finished.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int OPW = 4;   // adder operand width
  localparam int VCW = 16;  // vector counter width
  localparam int ECW = 8;   // error counter width

  localparam logic [ECW-1:0] ERR_MAX = 8'd255;  // error counter saturation value

endpackage
`default_nettype wire

// File: rtl/adder_golden_model.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : adder_golden_model                                         |
// | Description : Combinational 4-bit ripple-carry reference adder. Supplies |
// |               the expected sum, internal carries and carry-out for the   |
// |               response checker.                                          |
// | Revision    : 1.0 - initial release                                      |
// |                                                                          |
// | Ports                                                                    |
// |   a     in  [3:0]  operand A                                             |
// |   b     in  [3:0]  operand B                                             |
// |   cin   in         carry-in                                              |
// |   gs    out [3:0]  expected sum                                          |
// |   gc    out [3:1]  expected carry into bit i                             |
// |   gcout out        expected carry-out                                    |
// +--------------------------------------------------------------------------+
module adder_golden_model
  import adder_chk_pkg::*;
(
  input  logic [OPW-1:0] a,
  input  logic [OPW-1:0] b,
  input  logic           cin,
  output logic [OPW-1:0] gs,
  output logic [OPW-1:1] gc,
  output logic           gcout
);

  // w_carry[i] is the carry into bit i; w_carry[OPW] is the carry-out.
  logic [OPW:0] w_carry;

  assign w_carry[0] = cin;

  genvar gi;
  generate
    for (gi = 0; gi < OPW; gi++) begin : g_bit
      assign gs[gi]        = a[gi] ^ b[gi] ^ w_carry[gi];
      assign w_carry[gi+1] = (a[gi] & b[gi]) | (w_carry[gi] & (a[gi] ^ b[gi]));
    end
  endgenerate

  assign gc    = w_carry[OPW-1:1];
  assign gcout = w_carry[OPW];

endmodule
`default_nettype wire

// File: rtl/adder_response_checker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : adder_response_checker                                     |
// | Description : Two-stage response checker for a 4-bit parallel adder.     |
// |               Stage 1 registers each offered vector; stage 2 compares it |
// |               against a ripple reference, counts vectors and errors and  |
// |               keeps the first failing vector.                            |
// | Revision    : 1.0 - initial release                                      |
// |                                                                          |
// | Parameters                                                               |
// |   NUM_VECTORS   vectors accepted before the run ends (1..65535)          |
// |   CHECK_CARRIES 1: internal carries are compared, 0: only s and cout     |
// |                                                                          |
// | Ports                                                                    |
// |   clk, rst_n      clock (rising edge), synchronous active-low reset      |
// |   clear           synchronous restart of the run                         |
// |   in_valid        a/b/cin/s/c/cout form one vector this cycle            |
// |   a, b, cin       adder stimulus                                         |
// |   s, c, cout      adder response under test (c = carries c[3:1])        |
// |   busy, done      state is RUN / state is DONE                           |
// |   pass, fail      run finished clean / at least one error seen           |
// |   mismatch        one-cycle pulse per failing vector                     |
// |   vec_count       vectors checked                                        |
// |   err_count       failing vectors, saturating                            |
// |   ff_*            fields of the first failing vector                     |
// +--------------------------------------------------------------------------+
module adder_response_checker
  import adder_chk_pkg::*;
#(
  parameter int NUM_VECTORS   = 256,
  parameter int CHECK_CARRIES = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clear,
  input  logic           in_valid,
  input  logic [OPW-1:0] a,
  input  logic [OPW-1:0] b,
  input  logic           cin,
  input  logic [OPW-1:0] s,
  input  logic [OPW-1:1] c,
  input  logic           cout,
  output logic           busy,
  output logic           done,
  output logic           pass,
  output logic           fail,
  output logic           mismatch,
  output logic [VCW-1:0] vec_count,
  output logic [ECW-1:0] err_count,
  output logic [OPW-1:0] ff_a,
  output logic [OPW-1:0] ff_b,
  output logic           ff_cin,
  output logic [OPW-1:0] ff_s,
  output logic           ff_cout
);

  localparam logic [VCW-1:0] c_num_vec     = VCW'(NUM_VECTORS);
  localparam logic           c_chk_carries = (CHECK_CARRIES != 0);

  // FSM state
  state_e state_q, state_d;

  // Stage 1 capture register
  logic           v1_q, v1_d;
  logic [OPW-1:0] a1_q, a1_d;
  logic [OPW-1:0] b1_q, b1_d;
  logic           cin1_q, cin1_d;
  logic [OPW-1:0] s1_q, s1_d;
  logic [OPW-1:1] c1_q, c1_d;
  logic           cout1_q, cout1_d;

  // Stage 2 results
  logic           mismatch_q, mismatch_d;
  logic [VCW-1:0] vec_count_q, vec_count_d;
  logic [ECW-1:0] err_count_q, err_count_d;
  logic           pass_q, pass_d;
  logic           fail_q, fail_d;

  // First-fail capture
  logic [OPW-1:0] ff_a_q, ff_a_d;
  logic [OPW-1:0] ff_b_q, ff_b_d;
  logic           ff_cin_q, ff_cin_d;
  logic [OPW-1:0] ff_s_q, ff_s_d;
  logic           ff_cout_q, ff_cout_d;

  // Reference results for the vector held in stage 1
  logic [OPW-1:0] w_gs;
  logic [OPW-1:1] w_gc;
  logic           w_gcout;
  logic           w_miss;
  logic           w_capture;
  logic           w_check;

  adder_golden_model u_golden (
    .a     (a1_q),
    .b     (b1_q),
    .cin   (cin1_q),
    .gs    (w_gs),
    .gc    (w_gc),
    .gcout (w_gcout)
  );

  assign w_miss = (s1_q != w_gs) || (cout1_q != w_gcout) ||
                  (c_chk_carries && (c1_q != w_gc));

  // Vectors are not taken once the run has finished.
  assign w_capture = in_valid && (state_q != DONE);

  // Only a vector captured while the run is live is checked; the vector
  // captured on the edge that finishes the run is dropped here.
  assign w_check = v1_q && (state_q == RUN);

  always_comb begin
    state_d     = state_q;
    v1_d        = w_capture;
    a1_d        = a1_q;
    b1_d        = b1_q;
    cin1_d      = cin1_q;
    s1_d        = s1_q;
    c1_d        = c1_q;
    cout1_d     = cout1_q;
    mismatch_d  = w_check && w_miss;
    vec_count_d = vec_count_q;
    err_count_d = err_count_q;
    ff_a_d      = ff_a_q;
    ff_b_d      = ff_b_q;
    ff_cin_d    = ff_cin_q;
    ff_s_d      = ff_s_q;
    ff_cout_d   = ff_cout_q;

    if (w_capture) begin
      a1_d    = a;
      b1_d    = b;
      cin1_d  = cin;
      s1_d    = s;
      c1_d    = c;
      cout1_d = cout;
    end

    if (w_check && (vec_count_q < c_num_vec)) begin
      vec_count_d = vec_count_q + VCW'(1);
    end

    if (w_check && w_miss) begin
      if (err_count_q != ERR_MAX) begin
        err_count_d = err_count_q + ECW'(1);
      end
      // Error count still zero means this is the first failure of the run.
      if (err_count_q == '0) begin
        ff_a_d    = a1_q;
        ff_b_d    = b1_q;
        ff_cin_d  = cin1_q;
        ff_s_d    = s1_q;
        ff_cout_d = cout1_q;
      end
    end

    case (state_q)
      IDLE: if (in_valid) state_d = RUN;
      RUN:  if (w_check && (vec_count_d == c_num_vec)) state_d = DONE;
      DONE: state_d = DONE;
      default: state_d = IDLE;
    endcase

    // Restart overrides everything, including a vector offered this cycle
    // and the one waiting in stage 1.
    if (clear) begin
      state_d     = IDLE;
      v1_d        = 1'b0;
      mismatch_d  = 1'b0;
      vec_count_d = '0;
      err_count_d = '0;
      ff_a_d      = '0;
      ff_b_d      = '0;
      ff_cin_d    = 1'b0;
      ff_s_d      = '0;
      ff_cout_d   = 1'b0;
    end

    pass_d = (state_d == DONE) && (err_count_d == '0);
    fail_d = (err_count_d != '0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      v1_q        <= 1'b0;
      a1_q        <= '0;
      b1_q        <= '0;
      cin1_q      <= 1'b0;
      s1_q        <= '0;
      c1_q        <= '0;
      cout1_q     <= 1'b0;
      mismatch_q  <= 1'b0;
      vec_count_q <= '0;
      err_count_q <= '0;
      pass_q      <= 1'b0;
      fail_q      <= 1'b0;
      ff_a_q      <= '0;
      ff_b_q      <= '0;
      ff_cin_q    <= 1'b0;
      ff_s_q      <= '0;
      ff_cout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      v1_q        <= v1_d;
      a1_q        <= a1_d;
      b1_q        <= b1_d;
      cin1_q      <= cin1_d;
      s1_q        <= s1_d;
      c1_q        <= c1_d;
      cout1_q     <= cout1_d;
      mismatch_q  <= mismatch_d;
      vec_count_q <= vec_count_d;
      err_count_q <= err_count_d;
      pass_q      <= pass_d;
      fail_q      <= fail_d;
      ff_a_q      <= ff_a_d;
      ff_b_q      <= ff_b_d;
      ff_cin_q    <= ff_cin_d;
      ff_s_q      <= ff_s_d;
      ff_cout_q   <= ff_cout_d;
    end
  end

  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign pass      = pass_q;
  assign fail      = fail_q;
  assign mismatch  = mismatch_q;
  assign vec_count = vec_count_q;
  assign err_count = err_count_q;
  assign ff_a      = ff_a_q;
  assign ff_b      = ff_b_q;
  assign ff_cin    = ff_cin_q;
  assign ff_s      = ff_s_q;
  assign ff_cout   = ff_cout_q;

endmodule
`default_nettype wire

// File: tb/tb_adder_response_checker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_adder_response_checker                                  |
// | Description : Directed bench for adder_response_checker. Instance X     |
// |               (512 vectors, carries checked) is followed by a mismatch   |
// |               scoreboard; instance Y (1 vector, carries ignored) shares  |
// |               the same stimulus.                                         |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_adder_response_checker;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clear;
  logic       in_valid;
  logic [3:0] a, b, s;
  logic       cin, cout;
  logic [2:0] c;

  logic        x_busy, x_done, x_pass, x_fail, x_mismatch, x_ff_cin, x_ff_cout;
  logic [15:0] x_vec;
  logic [7:0]  x_err;
  logic [3:0]  x_ff_a, x_ff_b, x_ff_s;

  logic        y_busy, y_done, y_pass, y_fail, y_mismatch, y_ff_cin, y_ff_cout;
  logic [15:0] y_vec;
  logic [7:0]  y_err;
  logic [3:0]  y_ff_a, y_ff_b, y_ff_s;

  int total = 0;
  int bad   = 0;

  // Scoreboard for instance X: expected mismatch bit per accepted vector.
  logic sb_q[$];
  int   model_cnt = 0;
  logic push_flag = 1'b0;
  logic pend      = 1'b0;
  logic mon_acc;
  logic mon_flush;
  logic mon_exp;

  always #5 clk = ~clk;

  adder_response_checker #(.NUM_VECTORS(512), .CHECK_CARRIES(1)) dut_x (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid),
    .a(a), .b(b), .cin(cin), .s(s), .c(c), .cout(cout),
    .busy(x_busy), .done(x_done), .pass(x_pass), .fail(x_fail),
    .mismatch(x_mismatch), .vec_count(x_vec), .err_count(x_err),
    .ff_a(x_ff_a), .ff_b(x_ff_b), .ff_cin(x_ff_cin), .ff_s(x_ff_s),
    .ff_cout(x_ff_cout)
  );

  adder_response_checker #(.NUM_VECTORS(1), .CHECK_CARRIES(0)) dut_y (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid),
    .a(a), .b(b), .cin(cin), .s(s), .c(c), .cout(cout),
    .busy(y_busy), .done(y_done), .pass(y_pass), .fail(y_fail),
    .mismatch(y_mismatch), .vec_count(y_vec), .err_count(y_err),
    .ff_a(y_ff_a), .ff_b(y_ff_b), .ff_cin(y_ff_cin), .ff_s(y_ff_s),
    .ff_cout(y_ff_cout)
  );

  // Arithmetic reference: returns {cout, c[3:1], s}.
  function automatic logic [7:0] gold(input logic [3:0] va, input logic [3:0] vb,
                                      input logic vcin);
    int t, lo;
    logic [7:0] r;
    t = int'(va) + int'(vb) + int'(vcin);
    r = 8'd0;
    r[3:0] = t[3:0];
    r[7]   = t[4];
    for (int i = 1; i <= 3; i++) begin
      lo = (int'(va) % (1 << i)) + (int'(vb) % (1 << i)) + int'(vcin);
      r[3 + i] = lo[i];
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Offer one vector on the current cycle, then advance to the next negedge.
  task automatic drive(input logic [3:0] va, input logic [3:0] vb, input logic vcin,
                       input logic [3:0] vs, input logic [2:0] vc, input logic vcout);
    logic [7:0] g;
    logic       em;
    a = va; b = vb; cin = vcin; s = vs; c = vc; cout = vcout;
    in_valid = 1'b1;
    g  = gold(va, vb, vcin);
    em = (vs != g[3:0]) || (vcout != g[7]) || (vc != g[6:4]);
    if (rst_n && !clear && (model_cnt < 512)) begin
      push_flag = 1'b1;
      sb_q.push_back(em);
      model_cnt++;
    end else begin
      push_flag = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic idle();
    in_valid  = 1'b0;
    push_flag = 1'b0;
  endtask

  task automatic do_clear();
    idle();
    clear = 1'b1;
    @(negedge clk);
    clear     = 1'b0;
    model_cnt = 0;
  endtask

  task automatic drive_good(input logic [3:0] va, input logic [3:0] vb, input logic vcin);
    logic [7:0] g;
    g = gold(va, vb, vcin);
    drive(va, vb, vcin, g[3:0], g[6:4], g[7]);
  endtask

  // Scoreboard monitor: the vector accepted at one edge is judged at the next.
  always @(posedge clk) begin
    mon_acc   = push_flag && in_valid;
    mon_flush = clear || !rst_n;
    #1;
    if (pend) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $error("FAIL sb_underflow observed=%0d expected=%0d", 0, 1);
      end else begin
        mon_exp = sb_q.pop_front();
        if (mon_flush) mon_exp = 1'b0;
        total++;
        assert (x_mismatch === mon_exp) else begin
          bad++;
          $error("FAIL sb_mismatch observed=%0b expected=%0b", x_mismatch, mon_exp);
        end
      end
    end
    pend = mon_acc && !mon_flush;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] g;
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0;
    a = '0; b = '0; cin = 1'b0; s = '0; c = '0; cout = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Reset state
    chk("rst_flags_x", {x_busy, x_done, x_pass, x_fail, x_mismatch}, 5'b0);
    chk("rst_counts_x", {x_vec, x_err}, 24'd0);
    chk("rst_ff_x", {x_ff_a, x_ff_b, x_ff_cin, x_ff_s, x_ff_cout}, 14'd0);
    chk("rst_all_y", {y_busy, y_done, y_pass, y_fail, y_mismatch, y_vec, y_err}, 29'd0);

    // Single-vector pass: 7 + 9 + 1 = 17
    drive(4'd7, 4'd9, 1'b1, 4'b0001, 3'b111, 1'b1);
    idle();
    chk("single_busy_y", y_busy, 1);
    @(negedge clk);
    chk("single_vec_y", y_vec, 1);
    chk("single_err_y", y_err, 0);
    chk("single_done_y", y_done, 1);
    chk("single_pass_y", y_pass, 1);
    chk("single_mis_y", y_mismatch, 0);
    chk("single_vec_x", x_vec, 1);
    chk("single_busy_x", x_busy, 1);

    // Sum fault: 3 + 4 reported as 6
    do_clear();
    chk("clear_idle_x", {x_busy, x_done, x_vec}, 18'd0);
    drive(4'd3, 4'd4, 1'b0, 4'd6, 3'b000, 1'b0);
    idle();
    @(negedge clk);
    chk("sum_mis", x_mismatch, 1);
    chk("sum_err", x_err, 1);
    chk("sum_ff", {x_ff_a, x_ff_b, x_ff_cin, x_ff_s, x_ff_cout}, {4'd3, 4'd4, 1'b0, 4'd6, 1'b0});
    chk("sum_fail", x_fail, 1);
    @(negedge clk);
    chk("sum_mis_pulse", x_mismatch, 0);

    // Carry-only fault: carries checked on X, ignored on Y
    do_clear();
    drive(4'd1, 4'd1, 1'b0, 4'd2, 3'b000, 1'b0);
    idle();
    @(negedge clk);
    chk("carry_err_x", x_err, 1);
    chk("carry_err_y", y_err, 0);
    chk("carry_pass_y", {y_pass, y_fail}, 2'b10);

    // Exhaustive sweep of all a, b, cin
    do_clear();
    for (int i = 0; i < 512; i++) begin
      g = 8'(i);
      drive_good(g[3:0], g[7:4], i[8]);
    end
    idle();
    chk("sweep_done_early", x_done, 0);
    chk("sweep_vec_511", x_vec, 511);
    @(negedge clk);
    chk("sweep_done", x_done, 1);
    chk("sweep_pass", x_pass, 1);
    chk("sweep_vec", x_vec, 512);
    chk("sweep_busy", x_busy, 0);
    // Vectors in DONE are ignored
    drive(4'd3, 4'd4, 1'b0, 4'd6, 3'b000, 1'b0);
    idle();
    @(negedge clk);
    chk("done_ignores", {x_vec, x_err}, {16'd512, 8'd0});

    // Saturation and first-fail hold
    do_clear();
    drive(4'd15, 4'd15, 1'b1, 4'd0, 3'b111, 1'b1);
    for (int i = 1; i < 300; i++) begin
      logic [3:0] ra, rb;
      logic       rc;
      ra = 4'($urandom_range(0, 15));
      rb = 4'($urandom_range(0, 15));
      rc = 1'($urandom_range(0, 1));
      g  = gold(ra, rb, rc);
      drive(ra, rb, rc, g[3:0] ^ 4'd1, g[6:4], g[7]);
    end
    idle();
    @(negedge clk);
    chk("sat_err", x_err, 255);
    chk("sat_vec", x_vec, 300);
    chk("sat_ff", {x_ff_a, x_ff_b, x_ff_cin, x_ff_s, x_ff_cout}, {4'd15, 4'd15, 1'b1, 4'd0, 1'b1});
    chk("sat_fail", {x_fail, x_done}, 2'b10);

    // Clear together with in_valid while running
    do_clear();
    drive_good(4'd2, 4'd5, 1'b0);
    drive_good(4'd8, 4'd8, 1'b1);
    drive(4'd9, 4'd9, 1'b0, 4'd0, 3'b000, 1'b0);
    clear = 1'b1;
    drive(4'd9, 4'd9, 1'b0, 4'd0, 3'b000, 1'b0);
    clear = 1'b0; model_cnt = 0;
    idle();
    chk("clr_counts", {x_vec, x_err, x_mismatch}, 25'd0);
    chk("clr_state", {x_busy, x_done, x_fail}, 3'd0);
    @(negedge clk);
    chk("clr_dropped", {x_vec, x_err, x_mismatch, x_busy}, 26'd0);

    // Same scenario with reset instead of clear
    drive_good(4'd2, 4'd5, 1'b0);
    drive_good(4'd8, 4'd8, 1'b1);
    drive(4'd9, 4'd9, 1'b0, 4'd0, 3'b000, 1'b0);
    rst_n = 1'b0;
    drive(4'd9, 4'd9, 1'b0, 4'd0, 3'b000, 1'b0);
    rst_n = 1'b1; model_cnt = 0;
    idle();
    chk("rstm_counts", {x_vec, x_err, x_mismatch}, 25'd0);
    chk("rstm_state", {x_busy, x_done, x_fail}, 3'd0);
    @(negedge clk);
    chk("rstm_dropped", {x_vec, x_err, x_mismatch, x_busy}, 26'd0);

    @(negedge clk);
    chk("sb_empty", sb_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
